// File: rtl/usb_in_fifo.sv
// usb_in_fifo
// Byte FIFO in front of the USB core's IN data path with packet-level
// retransmit. A producer pushes bytes; each IN transaction reads them through a
// speculative pointer. Bytes are released only when the host ACKs the packet.
// A failed or timed-out transaction leaves the committed read pointer alone, so
// the next IN replays the same bytes.
//
// Optional feature: define USB_IN_FIFO_OVF_EN to count write attempts made
// while full (saturating at 8'hFF). Otherwise ovf_count is tied to 0.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   wr_data/wr_valid     producer byte and write request
//   wr_ready             space available (committed level < 2^DEPTH_LOG2)
//   txn_start            pulse: IN data phase begins
//   txn_end              pulse: transaction finished (abort unless success)
//   data_strobe          core consumed the presented byte
//   success              pulse: host ACKed the packet (commit)
//   data_in/data_in_valid registered byte to the core; valid low = end of packet
//   level, empty         committed occupancy (wr_ptr - rd_ptr)
//   ovf_count            overflow attempt counter
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no packet in flight, data_in_valid low
// LOAD  | fetch mem[sp_ptr] into data_in, decide whether it is payload
// SEND  | byte presented; wait for strobe (or go DONE if not valid)
// DONE  | packet payload exhausted, wait for success/txn_end

module usb_in_fifo #(
  parameter int DEPTH_LOG2 = 7,
  parameter int MAX_PACKET = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  txn_start,
  input  logic                  txn_end,
  input  logic                  data_strobe,
  input  logic                  success,
  output logic [7:0]            data_in,
  output logic                  data_in_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic [7:0]            ovf_count
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [6:0] MAX_PKT_C = 7'(MAX_PACKET);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] sp_ptr;
  logic [6:0]    sent;

  logic wr_en;
  logic do_start;
  logic do_load;
  logic do_adv;
  logic do_commit;
  logic do_abort;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  // level never exceeds DEPTH, so its MSB is set exactly when full.
  assign wr_ready = ~level[DEPTH_LOG2];
  assign wr_en    = wr_valid & wr_ready;

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_load   = 1'b0;
    do_adv    = 1'b0;
    do_commit = 1'b0;
    do_abort  = 1'b0;

    case (state)
      S_IDLE: begin
        if (txn_start) begin
          do_start  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        do_load   = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (data_in_valid && data_strobe) begin
          do_adv    = 1'b1;
          state_nxt = S_LOAD;
        end else if (!data_in_valid) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Commit/abort end the packet from any active state and win over
    // a fetch or advance in the same cycle.
    if (state != S_IDLE) begin
      if (success) begin
        do_commit = 1'b1;
        do_load   = 1'b0;
        do_adv    = 1'b0;
        state_nxt = S_IDLE;
      end else if (txn_end) begin
        do_abort  = 1'b1;
        do_load   = 1'b0;
        do_adv    = 1'b0;
        state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      sp_ptr        <= '0;
      sent          <= '0;
      data_in       <= '0;
      data_in_valid <= 1'b0;
    end else begin
      if (do_start) begin
        sp_ptr <= rd_ptr;
        sent   <= '0;
      end
      if (do_load) begin
        data_in       <= mem[sp_ptr[DEPTH_LOG2-1:0]];
        data_in_valid <= (sp_ptr != wr_ptr) && (sent < MAX_PKT_C);
      end
      if (do_adv) begin
        sp_ptr <= sp_ptr + 1'b1;
        sent   <= sent + 1'b1;
      end
      if (do_commit) begin
        rd_ptr <= sp_ptr;
      end
      if (do_commit || do_abort) begin
        data_in_valid <= 1'b0;
      end
    end
  end

`ifdef USB_IN_FIFO_OVF_EN
  logic [7:0] ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (wr_valid && !wr_ready && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_usb_in_fifo.sv
module tb_usb_in_fifo;

  localparam int DL   = 7;
  localparam int DEP  = 1 << DL;
  localparam int MAXP = 64;

  logic          clk;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          txn_start;
  logic          txn_end;
  logic          data_strobe;
  logic          success;
  logic [7:0]    data_in;
  logic          data_in_valid;
  logic [DL:0]   level;
  logic          empty;
  logic [7:0]    ovf_count;

  int tests = 0;
  int fails = 0;

  // Reference model: committed FIFO contents as a plain byte queue.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int         ovf_m = 0;
  logic [7:0] mon_exp;

  usb_in_fifo #(.DEPTH_LOG2(DL), .MAX_PACKET(MAXP)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .txn_start     (txn_start),
    .txn_end       (txn_end),
    .data_strobe   (data_strobe),
    .success       (success),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .level         (level),
    .empty         (empty),
    .ovf_count     (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ovf_bump();
`ifdef USB_IN_FIFO_OVF_EN
    if (ovf_m < 255) ovf_m++;
`endif
  endtask

  // Monitor: every byte the core consumes is popped from the scoreboard.
  always @(negedge clk) begin
    if (!rst && data_in_valid && data_strobe) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected none at %0t", data_in, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("data_in", 32'(data_in), 32'(mon_exp));
      end
    end
  end

  task automatic check_status();
    chk("level", 32'(level), 32'(model_q.size()));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("wr_ready", 32'(wr_ready), 32'(model_q.size() < DEP));
    chk("ovf_count", 32'(ovf_count), 32'(ovf_m));
  endtask

  task automatic write_bytes(input int n, input bit rnd, input logic [7:0] base);
    logic [7:0] b;
    bit acc;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : base + 8'(i);
      if (rnd && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        cyc();
      end
      wr_valid = 1'b1;
      wr_data  = b;
      acc = (model_q.size() < DEP);
      chk("wr_ready_w", 32'(wr_ready), 32'(acc));
      cyc();
      if (acc) model_q.push_back(b);
      else ovf_bump();
    end
    wr_valid = 1'b0;
  endtask

  // mode: 0 success, 1 abort, 2 success+txn_end together, 3 success with a write
  task automatic do_txn(input int kmax, input int mode);
    int n, k, cnt;
    bit acc;
    logic [7:0] b;
    n = (model_q.size() < MAXP) ? model_q.size() : MAXP;
    k = (n < kmax) ? n : kmax;
    for (int i = 0; i < k; i++) exp_q.push_back(model_q[i]);
    txn_start = 1'b1;
    cyc();
    txn_start = 1'b0;
    cyc();
    cnt = 0;
    for (int g = 0; g <= MAXP; g++) begin
      if (data_in_valid && cnt < k) begin
        data_strobe = 1'b1;
        cyc();
        data_strobe = 1'b0;
        cnt++;
        cyc();
      end else begin
        break;
      end
    end
    chk("strobes", 32'(cnt), 32'(k));
    chk("valid_at_end", 32'(data_in_valid), 32'(k < n));
    if (k == n) begin
      cyc();
      chk("valid_stays_low", 32'(data_in_valid), 32'd0);
    end
    acc = 1'b0;
    b = 8'($urandom);
    case (mode)
      0: success = 1'b1;
      1: txn_end = 1'b1;
      2: begin success = 1'b1; txn_end = 1'b1; end
      default: begin
        success  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = b;
        acc = (model_q.size() < DEP);
      end
    endcase
    cyc();
    success  = 1'b0;
    txn_end  = 1'b0;
    wr_valid = 1'b0;
    if (mode != 1) begin
      for (int i = 0; i < k; i++) void'(model_q.pop_front());
    end
    if (mode == 3) begin
      if (acc) model_q.push_back(b);
      else ovf_bump();
    end
    if (mode == 0) begin
      txn_end = 1'b1;
      cyc();
      txn_end = 1'b0;
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("valid_idle", 32'(data_in_valid), 32'd0);
    check_status();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_data = '0;
    wr_valid = 1'b0;
    txn_start = 1'b0;
    txn_end = 1'b0;
    data_strobe = 1'b0;
    success = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_valid", 32'(data_in_valid), 32'd0);
    check_status();

    // 01..0A, full packet, commit
    write_bytes(10, 1'b0, 8'h01);
    check_status();
    do_txn(999, 0);

    // 100 bytes -> 64 then 36
    write_bytes(100, 1'b0, 8'h20);
    do_txn(999, 0);
    chk("level_after_64", 32'(level), 32'd36);
    do_txn(999, 0);

    // partial then abort, replay from the first byte
    write_bytes(5, 1'b0, 8'hA0);
    do_txn(3, 1);
    chk("level_after_abort", 32'(level), 32'd5);
    do_txn(999, 0);

    // empty FIFO: zero-length packet
    do_txn(999, 0);

    // fill to full plus 3 overflow attempts
    write_bytes(DEP + 3, 1'b0, 8'h40);
    check_status();
    chk("full_level", 32'(level), 32'(DEP));
    do_txn(999, 0);
    chk("level_after_full_commit", 32'(level), 32'(DEP - MAXP));
    write_bytes(50, 1'b1, 8'h00);
    do_txn(999, 0);
    do_txn(999, 0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      write_bytes($urandom_range(0, 80), 1'b1, 8'h00);
      do_txn(($urandom_range(0, 1) == 0) ? 999 : $urandom_range(0, 70),
             $urandom_range(0, 3));
    end

    // reset mid-packet after two strobes
    write_bytes(5, 1'b0, 8'hC0);
    exp_q.push_back(model_q[0]);
    exp_q.push_back(model_q[1]);
    txn_start = 1'b1;
    cyc();
    txn_start = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      data_strobe = 1'b1;
      cyc();
      data_strobe = 1'b0;
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_q.delete();
    ovf_m = 0;
    chk("rst_mid_valid", 32'(data_in_valid), 32'd0);
    chk("rst_mid_sb", 32'(exp_q.size()), 32'd0);
    check_status();
    write_bytes(4, 1'b0, 8'hE0);
    do_txn(999, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
